// File: rtl/op_sequencer_pkg.sv
// rtl/op_sequencer_pkg.sv - shared array package: controller and sequencer state encodings
package op_sequencer_pkg;

  typedef enum logic [1:0] {
    CTRL_RESET = 2'd0,
    CTRL_LOAD  = 2'd1,
    CTRL_READY = 2'd2,
    CTRL_RUN   = 2'd3
  } array_ctrl_state_t;

  typedef enum logic [2:0] {
    SEQ_IDLE  = 3'd0,
    SEQ_LOAD  = 3'd1,
    SEQ_READY = 3'd2,
    SEQ_START = 3'd3,
    SEQ_FLUSH = 3'd4
  } seq_state_t;

  localparam int FLUSH_LEN = 2;

endpackage

// File: rtl/op_sequencer_phase_counter.sv
// rtl/op_sequencer_phase_counter.sv - loadable down-counter flagging the last cycle of a phase
module phase_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             f_sel_rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk_i or posedge f_sel_rst) begin
    if (f_sel_rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  // A count of one marks the final cycle of the running phase.
  assign expired = (count == WIDTH'(1));

endmodule

// File: rtl/op_sequencer.sv
// rtl/op_sequencer.sv - sequences the LOAD/READY/START/FLUSH handshake to the array controller
module op_sequencer
  import op_sequencer_pkg::*;
#(
  parameter int N             = 3,
  parameter int LEN_WIDTH     = 16,
  parameter int NUM_COL_WIDTH = $clog2(N + 1),
  parameter int SEL_WIDTH     = $clog2(N)
) (
  input  logic                     clk_i,
  input  logic                     f_sel_rst,
  input  logic                     go_i,
  input  logic                     abort_i,
  input  logic [LEN_WIDTH-1:0]     load_len_i,
  input  logic [LEN_WIDTH-1:0]     ready_len_i,
  input  logic [LEN_WIDTH-1:0]     op_len_i,
  input  logic [NUM_COL_WIDTH-1:0] column_num_cfg_i,
  input  logic [SEL_WIDTH-1:0]     f_sel_cfg_i,
  input  logic [NUM_COL_WIDTH-1:0] filter_size_cfg_i,
  output logic                     rst_o,
  output logic                     load_o,
  output logic                     ready_o,
  output logic                     start_op_o,
  output logic [NUM_COL_WIDTH-1:0] column_num_o,
  output logic [SEL_WIDTH-1:0]     f_sel_o,
  output logic [NUM_COL_WIDTH-1:0] filter_size_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [LEN_WIDTH-1:0]     op_count_o
);

  seq_state_t           state, state_next;
  logic [LEN_WIDTH-1:0] ready_len_q, op_len_q;
  logic [1:0]           flush_cnt;
  logic                 cnt_load, cnt_dec, cnt_expired;
  logic [LEN_WIDTH-1:0] cnt_value;

  function automatic logic [LEN_WIDTH-1:0] at_least_one(input logic [LEN_WIDTH-1:0] v);
    return (v == '0) ? LEN_WIDTH'(1) : v;
  endfunction

  phase_counter #(.WIDTH(LEN_WIDTH)) u_phase_counter (
    .clk_i      (clk_i),
    .f_sel_rst  (f_sel_rst),
    .load       (cnt_load),
    .load_value (cnt_value),
    .dec        (cnt_dec),
    .expired    (cnt_expired)
  );

  always_comb begin
    state_next = state;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    cnt_value  = '0;
    case (state)
      SEQ_IDLE: begin
        if (go_i) begin
          state_next = SEQ_LOAD;
          cnt_load   = 1'b1;
          cnt_value  = at_least_one(load_len_i);
        end
      end
      SEQ_LOAD: begin
        if (abort_i) begin
          state_next = SEQ_FLUSH;
        end else if (cnt_expired) begin
          state_next = SEQ_READY;
          cnt_load   = 1'b1;
          cnt_value  = at_least_one(ready_len_q);
        end else begin
          cnt_dec = 1'b1;
        end
      end
      SEQ_READY: begin
        if (abort_i) begin
          state_next = SEQ_FLUSH;
        end else if (cnt_expired) begin
          state_next = SEQ_START;
          cnt_load   = 1'b1;
          cnt_value  = at_least_one(op_len_q);
        end else begin
          cnt_dec = 1'b1;
        end
      end
      SEQ_START: begin
        // A zero op length keeps START running until an abort arrives.
        if (abort_i) begin
          state_next = SEQ_FLUSH;
        end else if ((op_len_q != '0) && cnt_expired) begin
          state_next = SEQ_FLUSH;
        end else if (op_len_q != '0) begin
          cnt_dec = 1'b1;
        end
      end
      SEQ_FLUSH: begin
        if (flush_cnt == 2'(FLUSH_LEN - 1)) begin
          state_next = SEQ_IDLE;
        end
      end
      default: state_next = SEQ_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk_i or posedge f_sel_rst) begin
    if (f_sel_rst) begin
      state         <= SEQ_IDLE;
      flush_cnt     <= 2'd0;
      ready_len_q   <= '0;
      op_len_q      <= '0;
      rst_o         <= 1'b1;
      load_o        <= 1'b0;
      ready_o       <= 1'b0;
      start_op_o    <= 1'b0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      op_count_o    <= '0;
      column_num_o  <= '0;
      f_sel_o       <= '0;
      filter_size_o <= '0;
    end else begin
      state      <= state_next;
      flush_cnt  <= (state == SEQ_FLUSH) ? flush_cnt + 2'd1 : 2'd0;
      rst_o      <= (state_next == SEQ_IDLE) || (state_next == SEQ_FLUSH);
      load_o     <= (state_next == SEQ_LOAD);
      ready_o    <= (state_next == SEQ_READY);
      start_op_o <= (state_next == SEQ_START);
      busy_o     <= (state_next != SEQ_IDLE);
      done_o     <= (state == SEQ_FLUSH) && (flush_cnt == 2'(FLUSH_LEN - 2));

      if ((state == SEQ_IDLE) && go_i) begin
        ready_len_q   <= ready_len_i;
        op_len_q      <= op_len_i;
        f_sel_o       <= f_sel_cfg_i;
        filter_size_o <= filter_size_cfg_i;
        column_num_o  <= ((column_num_cfg_i == '0) || (column_num_cfg_i > NUM_COL_WIDTH'(N)))
                         ? NUM_COL_WIDTH'(N) : column_num_cfg_i;
      end

      if ((state == SEQ_IDLE) && (state_next == SEQ_LOAD)) begin
        op_count_o <= '0;
      end else if ((state_next == SEQ_START) && (op_count_o != '1)) begin
        op_count_o <= op_count_o + 1'b1;
      end
    end
  end

endmodule

// File: doc/op_sequencer.md
OP_SEQUENCER -- requirements
Module: op_sequencer

Interface
REQ-001 Parameters SHALL be: N, default 3, array dimension; LEN_WIDTH, default 16, width of phase-length fields; NUM_COL_WIDTH, default $clog2(N+1), column-count width; SEL_WIDTH, default $clog2(N), filter-select width.
REQ-002 clk_i  input  1  clock; all state changes on its rising edge.
REQ-003 f_sel_rst  input  1  reset, asynchronous, active-high.
REQ-004 go_i  input  1  request to run one load/ready/start operation.
REQ-005 abort_i  input  1  terminate the current operation early.
REQ-006 load_len_i, ready_len_i, op_len_i  input  LEN_WIDTH each  lengths in cycles of the LOAD, READY and START phases; op_len_i = 0 means run until abort.
REQ-007 column_num_cfg_i  input  NUM_COL_WIDTH  column count (1..N) to present to the array controller.
REQ-008 f_sel_cfg_i  input  SEL_WIDTH  filter select to present.
REQ-009 filter_size_cfg_i  input  NUM_COL_WIDTH  filter size to present.
REQ-010 rst_o, load_o, ready_o, start_op_o  output  1 each  registered handshake to the array controller.
REQ-011 column_num_o  output  NUM_COL_WIDTH; f_sel_o  output  SEL_WIDTH; filter_size_o  output  NUM_COL_WIDTH; all hold the latched configuration.
REQ-012 busy_o  output  1  high in every state except IDLE.
REQ-013 done_o  output  1  one-cycle completion pulse.
REQ-014 op_count_o  output  LEN_WIDTH  count of START cycles elapsed in the current operation.

Function
REQ-015 The FSM SHALL have the states IDLE, LOAD, READY, START and FLUSH, encoded as a 3-bit value.
REQ-016 In IDLE the block SHALL drive rst_o=1, drive load_o, ready_o and start_op_o low, and on go_i=1 latch all *_cfg_i and *_len_i inputs and enter LOAD on the next edge.
REQ-017 In LOAD the block SHALL drive load_o=1 and rst_o=0 for exactly max(load_len,1) cycles, then enter READY.
REQ-018 On the LOAD-to-READY edge, load_o SHALL fall and ready_o SHALL rise in the same cycle, so that load and ready are never high together and never low together at the boundary.
REQ-019 In READY the block SHALL drive ready_o=1 for exactly max(ready_len,1) cycles, then enter START, with ready_o falling and start_op_o rising on the same edge.
REQ-020 In START the block SHALL drive start_op_o=1, increment op_count_o every cycle (saturating at all-ones), and leave after op_len cycles, or only on abort_i when op_len=0.
REQ-021 In FLUSH the block SHALL drive rst_o=1 with the other handshake outputs low for exactly 2 cycles, pulse done_o on the second cycle, then return to IDLE.
REQ-022 abort_i=1 in LOAD, READY or START SHALL force FLUSH on the next edge; abort_i in IDLE or FLUSH SHALL be ignored.
REQ-023 go_i SHALL be ignored while busy_o=1, and the latched configuration SHALL NOT change until the next accepted go_i.
REQ-024 If go_i and abort_i are both high in IDLE, go_i SHALL win.
REQ-025 column_num_cfg_i = 0 or greater than N SHALL be clamped to N when latched.
REQ-026 op_count_o SHALL clear to 0 on entry to LOAD and hold its value through FLUSH and IDLE.
REQ-027 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-028 Asserting f_sel_rst SHALL immediately force IDLE with rst_o=1, load_o=ready_o=start_op_o=0, busy_o=0, done_o=0, op_count_o=0, column_num_o=0, f_sel_o=0 and filter_size_o=0.
REQ-029 Asserting f_sel_rst mid-operation SHALL abandon the operation without a done_o pulse.

Structure
REQ-030 The state encoding and the FLUSH length (2) SHALL live in the shared array package alongside the controller state encodings.
REQ-031 One sub-module, phase_counter, SHALL be used: a loadable down-counter with an expiry flag shared by the LOAD, READY and START phases.

Verification
REQ-032 Normal run: go_i with load_len=3, ready_len=2, op_len=5 -> load_o high 3 cycles, ready_o high 2 cycles, start_op_o high 5 cycles, rst_o high 2 cycles, done_o pulse, op_count_o=5.
REQ-033 Zero lengths: load_len=0, ready_len=0, op_len=4 -> load_o and ready_o each high for 1 cycle, then start_op_o high for 4 cycles.
REQ-034 Open-ended run: op_len=0 with abort_i asserted after 10 START cycles -> op_count_o=10, FLUSH entered, done_o pulses.
REQ-035 Mid-START reset: f_sel_rst asserted in cycle 2 of START -> outputs take reset values immediately, no done_o pulse, and go_i afterwards restarts cleanly.
REQ-036 Configuration handling: column_num_cfg_i=0 with N=3 -> column_num_o=3; changing f_sel_cfg_i while busy -> f_sel_o unchanged.
REQ-037 Simultaneous events: go_i held high through a whole operation -> exactly one operation per go_i edge accepted in IDLE; go_i and abort_i together in IDLE -> LOAD entered.
